// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the multi-digit BCD counter and its 7-segment decoders.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low a..g with segment a in bit 6.
    localparam logic [6:0] SEG_PAT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    function automatic int clogb2(input longint n);
        int w;
        w = 1;
        while ((64'd1 << w) < n)
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Single BCD digit to active-low 7-segment decoder; non-decimal codes blank the display.
module bcd_seg_decode
    import bcd_counter_pkg::*;
(
    input  bcd_digit_t   bcd_i,
    output logic [6:0]   seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9)
            seg_o = SEG_PAT[bcd_i];
    end

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD counter with tick prescaler, load, wrap pulse and 7-segment outputs.
// Define UPDOWN_EN to honour the up input; otherwise the counter is up-only.
module bcd_counter_multi
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tick,
    output logic                  carry,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int              PRE_W   = clogb2(longint'(TICK_DIV));
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic [4*DIGITS-1:0] step_val, load_clean;
    logic                wrap;

`ifdef UPDOWN_EN
    logic dir_up;
    assign dir_up = up;
`else
    logic unused_up;
    assign unused_up = up;
`endif

    assign tick = enable && (pre_q == PRE_MAX);

    // Ripple the +1/-1 through the digits; wrap is the carry/borrow out of the top digit.
    always_comb begin
        bcd_digit_t d;
        logic       c;
        step_val = cnt_q;
        c        = 1'b1;
        d        = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = cnt_q[4*i +: 4];
            if (c) begin
`ifdef UPDOWN_EN
                if (!dir_up) begin
                    if (d == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = 4'(d - 4'd1);
                        c = 1'b0;
                    end
                end else
`endif
                if (d == 4'd9) begin
                    step_val[4*i +: 4] = 4'd0;
                end else begin
                    step_val[4*i +: 4] = 4'(d + 4'd1);
                    c = 1'b0;
                end
            end
        end
        wrap = c;
    end

    always_comb begin
        load_clean = '0;
        for (int i = 0; i < DIGITS; i++)
            load_clean[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end

    // Load outranks the step and restarts the prescaler phase.
    always_comb begin
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        carry_d = 1'b0;
        if (load) begin
            cnt_d = load_clean;
            pre_d = '0;
        end else begin
            if (enable)
                pre_d = tick ? '0 : PRE_W'(pre_q + 1'b1);
            if (tick) begin
                cnt_d   = step_val;
                carry_d = wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            cnt_q   <= '0;
            pre_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            carry_q <= carry_d;
        end
    end

    assign q     = cnt_q;
    assign carry = carry_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_seg_decode u_dec (
            .bcd_i (cnt_q[4*g +: 4]),
            .seg_o (seg[7*g +: 7])
        );
    end

endmodule

// File: doc/bcd_counter_multi.md
# bcd_counter_multi

Parametrised multi-digit decimal (BCD) counter with a built-in tick prescaler, synchronous load, optional up/down counting, a wrap pulse and per-digit active-low 7-segment outputs. It replaces single-digit modulo counters that were cascaded by hand. It sits between the board clock and the HEX displays: one instance drives DIGITS displays directly from the 50 MHz clock.

## Interface
- DIGITS, 4: number of BCD digits (1..8); the count range is 0 .. 10^DIGITS-1.
- TICK_DIV, 50000000: prescaler modulus in clk cycles per count step (>=1).
- clk  in  1  system clock, rising edge.
- aclr  in  1  reset, asynchronous, active-low.
- enable  in  1  run enable; gates both the prescaler and counting.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD load value; digit i is in [4i+3:4i].
- up  in  1  direction: 1 = up, 0 = down. Used only with UPDOWN_EN.
- q  out  4*DIGITS  current BCD count; digit 0 is least significant.
- tick  out  1  prescaler step strobe, combinational.
- carry  out  1  registered one-cycle pulse on wrap-around.
- seg  out  7*DIGITS  active-low segments; digit i is in [7i+6:7i], with bit 7i+6 = a and bit 7i = g.

## Operation
- Prescaler pre counts 0..TICK_DIV-1 while enable=1 and wraps to 0.
  - tick = enable && (pre == TICK_DIV-1). With TICK_DIV=1, tick = enable.
  - While enable=0, pre holds.
- Priority at each rising clk edge, highest first:
  - load=1: q <= load_val, with any digit >9 replaced by 0. pre <= 0. carry <= 0.
  - tick=1: step q by one in the current direction. carry <= 1 only if q wrapped, else 0.
  - Otherwise: q holds and carry <= 0.
- load works regardless of enable.
- Up step:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - All digits 9 becomes all 0 (wrap).
- Down step:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits 0 becomes all 9 (wrap).
- seg is a combinational decode of q. Patterns for digits 0..9 (a..g, active-low): 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. Any other code gives 1111111 (blank).

## Timing
- Reset values, immediate on aclr=0 with no clock needed: q=0, pre=0, carry=0, seg = 0000001 on every digit.
- tick is valid in the same cycle as pre and enable. q changes at the edge that closes a tick cycle.
- After aclr is released with enable=1, the first step of q occurs TICK_DIV edges later.
- carry is high for exactly the one cycle after the wrapping edge, i.e. while q shows the wrapped value.
- load and tick in the same cycle: the load wins, no step occurs, pre restarts at 0, and there is no carry.
- enable dropped mid-prescale: pre is frozen and counting resumes from the same phase.
- aclr asserted mid-operation: all state clears immediately and the carry pulse is cut short.

## Configuration
- UPDOWN_EN defined: the up input selects the direction every step.
- UPDOWN_EN undefined:
  - The counter is up-only and the up input is ignored.
  - No borrow/down logic is synthesised.
  - The port list is unchanged.

## Structure
- Package bcd_counter_pkg holds:
  - the clogb2 function, used to size pre,
  - the bcd_digit_t typedef (4-bit),
  - the SEG_BLANK constant,
  - the 10-entry segment pattern constant array.
- Sub-module bcd_seg_decode: one 4-bit to 7-segment decoder, instantiated DIGITS times in a generate loop. The digit chain stays in the top module.

## Test plan
Unless noted, DIGITS=2 and TICK_DIV=4.
- Reset, then enable=1, up=1: q=0x00 during edges 1-3, q=0x01 after edge 4, q=0x00 after edge 400 with carry=1 for one cycle, and seg[13:0]=00000010000001 while q=0x00.
- Load 0x99 with up=1, then one tick: q=0x00 and carry pulses once. Load 0x3C: q=0x30.
- With UPDOWN_EN, up=0:
  - From 0x10, one tick gives 0x09.
  - From 0x00, one tick gives 0x99 with a carry pulse.
  - Without UPDOWN_EN, up=0 from 0x10 gives 0x11.
- load=1 in a cycle where tick=1 with load_val=0x42: q=0x42, no carry, and the next step comes 4 edges later.
- enable=0 for 10 cycles at pre=2: q and pre hold. After re-enable the step comes 2 edges later.
- aclr=0 pulse mid-count: q=0x00 and seg shows "00" with no clock edge.
- TICK_DIV=1: q steps every edge while enable=1.
